data_mem_responder: RTL and testbench

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

---
 rtl/data_mem_responder.sv | 146 ++++++++++++++
 tb/tb_data_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Byte-addressed, big-endian data memory with a registered request/response handshake.
// Optional feature macro DMEM_WAIT_EN inserts one WAIT cycle between accept and response.
module data_mem_responder #(
  parameter int DEPTH = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        readwrite,
  input  logic        size,
  input  logic [7:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        misalign
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e      state_q;
  logic [31:0] rdata_q;
  logic        ready_q;
  logic        busy_q;
  logic        misalign_q;
  logic [7:0]  mem_q [DEPTH];

  // The operation being completed this cycle, from live inputs or from the captured request.
  logic          complete;
  logic [AW-1:0] op_addr;
  logic [31:0]   op_wdata;
  logic          op_rw;
  logic          op_size;

`ifdef DMEM_WAIT_EN
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic          rw_q;
  logic          size_q;

  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && en) begin
      addr_q  <= addr[AW-1:0];
      wdata_q <= wdata;
      rw_q    <= readwrite;
      size_q  <= size;
    end
  end

  assign complete = (state_q == S_WAIT);
  assign op_addr  = addr_q;
  assign op_wdata = wdata_q;
  assign op_rw    = rw_q;
  assign op_size  = size_q;
`else
  assign complete = (state_q == S_IDLE) && en;
  assign op_addr  = addr[AW-1:0];
  assign op_wdata = wdata;
  assign op_rw    = readwrite;
  assign op_size  = size;
`endif

  logic          op_mis;
  logic [AW-1:0] a0, a1, a2, a3;
  logic [31:0]   load_val;

  assign op_mis = op_size && (op_addr[1:0] != 2'b00);
  assign a0     = {op_addr[AW-1:2], 2'd0};
  assign a1     = {op_addr[AW-1:2], 2'd1};
  assign a2     = {op_addr[AW-1:2], 2'd2};
  assign a3     = {op_addr[AW-1:2], 2'd3};

  // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    load_val = '0;
    if (op_size) load_val = {mem_q[a0], mem_q[a1], mem_q[a2], mem_q[a3]};
    else         load_val = {24'd0, mem_q[op_addr]};
  end

  // NOTE: the memory array has no reset; its contents must survive reset, only writes are gated.
  always_ff @(posedge clk) begin
    if (!reset && complete && op_rw && !op_mis) begin
      if (op_size) begin
        mem_q[a0] <= op_wdata[31:24];
        mem_q[a1] <= op_wdata[23:16];
        mem_q[a2] <= op_wdata[15:8];
        mem_q[a3] <= op_wdata[7:0];
      end else begin
        mem_q[op_addr] <= op_wdata[7:0];
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rdata_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      ready_q    <= 1'b0;
      misalign_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (en) begin
            busy_q <= 1'b1;
`ifdef DMEM_WAIT_EN
            state_q <= S_WAIT;
`else
            state_q <= S_RESP;
`endif
          end
        end
        S_WAIT: state_q <= S_RESP;
        S_RESP: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
      // Stores and misaligned accesses report zero; rdata otherwise holds between loads.
      if (complete) begin
        ready_q    <= 1'b1;
        misalign_q <= op_mis;
        rdata_q    <= (op_rw || op_mis) ? 32'd0 : load_val;
      end
    end
  end

  assign rdata    = rdata_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign misalign = misalign_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder; expected responses queue at issue, compared at ready.
module tb_data_mem_responder;

`ifdef DMEM_WAIT_EN
  localparam int LAT     = 2;
  localparam int EXP_B2B = 1;
`else
  localparam int LAT     = 1;
  localparam int EXP_B2B = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        en;
  logic        readwrite;
  logic        size;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ready;
  logic        busy;
  logic        misalign;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0] rd;
    logic        mis;
  } exp_t;

  exp_t sb_q[$];

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH(256)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .readwrite (readwrite),
    .size      (size),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .ready     (ready),
    .busy      (busy),
    .misalign  (misalign)
  );

  function automatic logic [7:0] pre_val(input int i);
    case (i)
      0: return 8'hDE;
      1: return 8'hAD;
      2: return 8'hBE;
      3: return 8'hEF;
      default: return 8'((i * 7 + 3) & 255);
    endcase
  endfunction

  // Issues one request, queues its expected response, then waits (bounded) for ready.
  task automatic run_req(input logic rw, input logic sz, input logic [7:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_mis,
                         output logic [31:0] got_rd, output logic got_mis, output logic got_busy,
                         output int lat);
    @(negedge clk);
    en = 1'b1; readwrite = rw; size = sz; addr = a; wdata = wd;
    sb_q.push_back('{rd: exp_rd, mis: exp_mis});
    @(negedge clk);
    en = 1'b0; readwrite = 1'b0; size = 1'b0;
    addr = 8'($urandom); wdata = $urandom;
    lat = 1;
    while (!ready && lat < 8) begin
      @(negedge clk);
      lat++;
    end
    if (!ready) lat = -1;
    got_rd = rdata; got_mis = misalign; got_busy = busy;
  endtask

  task automatic test_reset;
    reset = 1'b1; en = 1'b0; readwrite = 1'b0; size = 1'b0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) dut.mem_q[i] <= pre_val(i);
    repeat (2) @(negedge clk);
    total++; if (rdata !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
    total++; if ({ready, busy, misalign} !== 3'b000) begin
      bad++; $display("FAIL reset_flags got rdy/busy/mis=%b exp=000", {ready, busy, misalign});
    end
    // Reset and a store request on the same edge: reset wins, nothing written.
    en = 1'b1; readwrite = 1'b1; size = 1'b0; addr = 8'd20; wdata = 32'h77;
    @(negedge clk);
    total++; if ({ready, busy} !== 2'b00) begin
      bad++; $display("FAIL reset_prio_flags got rdy/busy=%b exp=00", {ready, busy});
    end
    total++; if (dut.mem_q[20] !== pre_val(20)) begin
      bad++; $display("FAIL reset_prio_mem got=%h exp=%h", dut.mem_q[20], pre_val(20));
    end
    en = 1'b0; readwrite = 1'b0; reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word_load;
    logic [31:0] rd; logic mis, bz; int lat; exp_t e;
    run_req(1'b0, 1'b1, 8'd0, 32'h0, 32'hDEADBEEF, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd) begin bad++; $display("FAIL word_load_rdata got=%h exp=%h", rd, e.rd); end
    total++; if ({mis, bz} !== {e.mis, 1'b1} || lat != LAT) begin
      bad++; $display("FAIL word_load_hs got mis/busy=%b lat=%0d exp=%b lat=%0d", {mis, bz}, lat, {e.mis, 1'b1}, LAT);
    end
    repeat (3) @(negedge clk);
    total++; if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rdata_hold got=%h exp=deadbeef", rdata); end
    total++; if ({ready, busy, misalign} !== 3'b000) begin
      bad++; $display("FAIL idle_flags got=%b exp=000", {ready, busy, misalign});
    end
  endtask

  task automatic test_byte_access;
    logic [31:0] rd; logic mis, bz; int lat; exp_t e;
    run_req(1'b1, 1'b0, 8'd5, 32'hFFFFFF5A, 32'd0, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || mis !== e.mis || lat != LAT) begin
      bad++; $display("FAIL byte_store_resp got rd=%h mis=%b lat=%0d exp rd=%h mis=%b lat=%0d", rd, mis, lat, e.rd, e.mis, LAT);
    end
    run_req(1'b0, 1'b0, 8'd5, 32'h0, 32'h0000005A, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || lat != LAT) begin
      bad++; $display("FAIL byte_load got rd=%h lat=%0d exp rd=%h lat=%0d", rd, lat, e.rd, LAT);
    end
    total++; if ({dut.mem_q[4], dut.mem_q[6], dut.mem_q[7]} !== {pre_val(4), pre_val(6), pre_val(7)}) begin
      bad++; $display("FAIL byte_neighbours got=%h %h %h exp=%h %h %h", dut.mem_q[4], dut.mem_q[6], dut.mem_q[7],
                      pre_val(4), pre_val(6), pre_val(7));
    end
    run_req(1'b0, 1'b0, 8'd3, 32'h0, 32'h000000EF, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || mis !== e.mis) begin
      bad++; $display("FAIL byte_load_odd got rd=%h mis=%b exp rd=%h mis=%b", rd, mis, e.rd, e.mis);
    end
  endtask

  task automatic test_word_store;
    logic [31:0] rd; logic mis, bz; int lat; exp_t e;
    run_req(1'b1, 1'b1, 8'd8, 32'h11223344, 32'd0, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || mis !== e.mis || lat != LAT) begin
      bad++; $display("FAIL word_store_resp got rd=%h mis=%b lat=%0d exp rd=%h mis=%b lat=%0d", rd, mis, lat, e.rd, e.mis, LAT);
    end
    run_req(1'b0, 1'b1, 8'd8, 32'h0, 32'h11223344, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd) begin bad++; $display("FAIL word_readback got=%h exp=%h", rd, e.rd); end
    total++; if ({dut.mem_q[8], dut.mem_q[11]} !== 16'h1144) begin
      bad++; $display("FAIL word_bytes got=%h %h exp=11 44", dut.mem_q[8], dut.mem_q[11]);
    end
  endtask

  task automatic test_misalign;
    logic [31:0] rd; logic mis, bz; int lat; exp_t e;
    run_req(1'b1, 1'b1, 8'd6, 32'hCAFEF00D, 32'd0, 1'b1, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || mis !== e.mis || lat != LAT) begin
      bad++; $display("FAIL mis_store got rd=%h mis=%b lat=%0d exp rd=%h mis=%b lat=%0d", rd, mis, lat, e.rd, e.mis, LAT);
    end
    total++; if ({dut.mem_q[4], dut.mem_q[5], dut.mem_q[6], dut.mem_q[7]} !==
                 {pre_val(4), 8'h5A, pre_val(6), pre_val(7)}) begin
      bad++; $display("FAIL mis_store_mem got=%h %h %h %h exp=%h 5a %h %h", dut.mem_q[4], dut.mem_q[5],
                      dut.mem_q[6], dut.mem_q[7], pre_val(4), pre_val(6), pre_val(7));
    end
    @(negedge clk);
    total++; if (misalign !== 1'b0) begin bad++; $display("FAIL mis_pulse got=%b exp=0", misalign); end
    run_req(1'b0, 1'b1, 8'd1, 32'h0, 32'd0, 1'b1, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || mis !== e.mis || lat != LAT) begin
      bad++; $display("FAIL mis_load got rd=%h mis=%b lat=%0d exp rd=%h mis=%b lat=%0d", rd, mis, lat, e.rd, e.mis, LAT);
    end
  endtask

  task automatic test_boundary;
    logic [31:0] rd; logic mis, bz; int lat; exp_t e;
    run_req(1'b1, 1'b1, 8'd252, 32'hA1B2C3D4, 32'd0, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || mis !== e.mis) begin
      bad++; $display("FAIL top_store got rd=%h mis=%b exp rd=%h mis=%b", rd, mis, e.rd, e.mis);
    end
    run_req(1'b0, 1'b1, 8'd252, 32'h0, 32'hA1B2C3D4, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd) begin bad++; $display("FAIL top_load got=%h exp=%h", rd, e.rd); end
    total++; if ({dut.mem_q[255], dut.mem_q[0]} !== 16'hD4DE) begin
      bad++; $display("FAIL top_nowrap got=%h %h exp=d4 de", dut.mem_q[255], dut.mem_q[0]);
    end
  endtask

  task automatic test_back_to_back;
    int  readies = 0;
    logic gap_ok = 1'b1;
    exp_t e;
    for (int k = 0; k < EXP_B2B; k++) sb_q.push_back('{rd: 32'h11223344, mis: 1'b0});
    @(negedge clk);
    en = 1'b1; readwrite = 1'b0; size = 1'b1; addr = 8'd8;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) en = 1'b0;
      if (ready) begin
        total++; if (gap_ok !== 1'b1) begin bad++; $display("FAIL b2b_gap got ready while busy never dropped"); end
        if (sb_q.size() > 0) begin
          e = sb_q.pop_front();
          total++; if (rdata !== e.rd) begin bad++; $display("FAIL b2b_rdata got=%h exp=%h", rdata, e.rd); end
        end
        readies++;
        gap_ok = 1'b0;
      end else if (!busy) begin
        gap_ok = 1'b1;
      end
    end
    total++; if (readies != EXP_B2B) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", readies, EXP_B2B); end
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL b2b_leftover got=%0d exp=0", sb_q.size()); end
    sb_q.delete();
  endtask

`ifdef DMEM_WAIT_EN
  task automatic test_wait_reset;
    logic [31:0] rd; logic mis, bz; int lat; exp_t e;
    @(negedge clk);
    en = 1'b1; readwrite = 1'b1; size = 1'b1; addr = 8'd12; wdata = 32'h12345678;
    @(negedge clk);
    en = 1'b0;
    total++; if ({ready, busy} !== 2'b01) begin bad++; $display("FAIL wait_state got rdy/busy=%b exp=01", {ready, busy}); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if ({ready, busy} !== 2'b00) begin bad++; $display("FAIL wait_abort got rdy/busy=%b exp=00", {ready, busy}); end
    total++; if ({dut.mem_q[12], dut.mem_q[13], dut.mem_q[14], dut.mem_q[15]} !==
                 {pre_val(12), pre_val(13), pre_val(14), pre_val(15)}) begin
      bad++; $display("FAIL wait_abort_mem got=%h%h%h%h", dut.mem_q[12], dut.mem_q[13], dut.mem_q[14], dut.mem_q[15]);
    end
    run_req(1'b0, 1'b1, 8'd12, 32'h0, {pre_val(12), pre_val(13), pre_val(14), pre_val(15)}, 1'b0, rd, mis, bz, lat);
    e = sb_q.pop_front();
    total++; if (rd !== e.rd || lat != LAT) begin
      bad++; $display("FAIL wait_after_abort got rd=%h lat=%0d exp rd=%h lat=%0d", rd, lat, e.rd, LAT);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_word_load();
    test_byte_access();
    test_word_store();
    test_misalign();
    test_boundary();
    test_back_to_back();
`ifdef DMEM_WAIT_EN
    test_wait_reset();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
